// File: rtl/regfile_wb.sv
// General-purpose register file fed by the MEM/WB write-back stream, with two
// bypassing read ports and a per-register pending-write scoreboard for RAW detection.
module regfile_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              iss_we,
  input  logic [ADDR_W-1:0] iss_waddr,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy2,
  output logic              sb_ovf
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  cnt  [NREG];
  logic [NREG-1:0]   inc_v;
  logic [NREG-1:0]   dec_v;
  logic              ovf_hit;

  // One-hot issue/retire strobes; register 0 never participates.
  always_comb begin
    inc_v   = '0;
    dec_v   = '0;
    ovf_hit = 1'b0;
    if (iss_we && iss_waddr != '0) inc_v[iss_waddr] = 1'b1;
    if (wb_we && wb_waddr != '0)   dec_v[wb_waddr]  = 1'b1;
    for (int r = 1; r < NREG; r++) begin
      if (inc_v[r] && !dec_v[r] && cnt[r] == CNT_MAX) ovf_hit = 1'b1;
      if (dec_v[r] && !inc_v[r] && cnt[r] == '0)      ovf_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      sb_ovf <= 1'b0;
    end else begin
      if (wb_we && wb_waddr != '0) regs[wb_waddr] <= wb_wdata;
      // Counters saturate at both ends; the overflow flag records the event.
      for (int r = 1; r < NREG; r++) begin
        if (inc_v[r] && !dec_v[r] && cnt[r] != CNT_MAX)
          cnt[r] <= cnt[r] + CNT_ONE;
        else if (dec_v[r] && !inc_v[r] && cnt[r] != '0)
          cnt[r] <= cnt[r] - CNT_ONE;
      end
      if (ovf_hit) sb_ovf <= 1'b1;
    end
  end

  assign rdata1 = (rst || !re1 || raddr1 == '0) ? '0 :
                  (wb_we && wb_waddr == raddr1) ? wb_wdata : regs[raddr1];
  assign rdata2 = (rst || !re2 || raddr2 == '0) ? '0 :
                  (wb_we && wb_waddr == raddr2) ? wb_wdata : regs[raddr2];

  // The last outstanding write landing this cycle is bypassed, so not busy.
  assign busy1 = !rst && re1 && raddr1 != '0 && cnt[raddr1] != '0 &&
                 !(wb_we && wb_waddr == raddr1 && cnt[raddr1] == CNT_ONE);
  assign busy2 = !rst && re2 && raddr2 != '0 && cnt[raddr2] != '0 &&
                 !(wb_we && wb_waddr == raddr2 && cnt[raddr2] == CNT_ONE);

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios plus a randomized
// write/read phase checked against a reference memory through an expected queue.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        iss_we;
  logic [4:0]  iss_waddr;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        busy1, busy2;
  logic        sb_ovf;

  logic [31:0] exp_q[$];
  logic [31:0] e;
  logic [31:0] model_mem [32];
  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .iss_we(iss_we), .iss_waddr(iss_waddr),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .busy1(busy1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2), .busy2(busy2),
    .sb_ovf(sb_ovf)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; checks happen 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    iss_we = 1'b0; iss_waddr = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [4:0] a);
    idle(); iss_we = 1'b1; iss_waddr = a;
    tick();
  endtask

  task automatic wback(input logic [4:0] a, input logic [31:0] d);
    idle(); wb_we = 1'b1; wb_waddr = a; wb_wdata = d;
    tick();
  endtask

  task automatic read_both(input logic [4:0] a);
    idle(); re1 = 1'b1; raddr1 = a; re2 = 1'b1; raddr2 = a;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 32; a++) begin
      read_both(5'(a));
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); n_tests++;
      if (rdata1 !== e) begin n_fail++; $display("FAIL reset_rd1 a=%0d got=%h exp=%h", a, rdata1, e); end
      e = exp_q.pop_front(); n_tests++;
      if (rdata2 !== e) begin n_fail++; $display("FAIL reset_rd2 a=%0d got=%h exp=%h", a, rdata2, e); end
      n_tests++;
      if (busy1 !== 1'b0 || busy2 !== 1'b0 || sb_ovf !== 1'b0) begin
        n_fail++; $display("FAIL reset_flags a=%0d busy1=%b busy2=%b ovf=%b exp=0", a, busy1, busy2, sb_ovf);
      end
      tick();
    end
    // Build up state, then assert reset between clock edges.
    wback(5'd5, 32'h0000_0011);
    issue(5'd8);
    wback(5'd10, 32'h0000_0022);
    idle(); #1;
    n_tests++;
    if (sb_ovf !== 1'b1) begin n_fail++; $display("FAIL pre_rst_ovf got=%b exp=1", sb_ovf); end
    idle(); re1 = 1'b1; raddr1 = 5'd8; re2 = 1'b1; raddr2 = 5'd9;
    wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'h5555_AAAA;
    #1;
    n_tests++;
    if (busy1 !== 1'b1 || rdata2 !== 32'h5555_AAAA) begin
      n_fail++; $display("FAIL pre_rst_state busy1=%b rdata2=%h exp 1/5555aaaa", busy1, rdata2);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || busy1 !== 1'b0 || busy2 !== 1'b0 || sb_ovf !== 1'b0) begin
      n_fail++; $display("FAIL async_rst rd1=%h rd2=%h b1=%b b2=%b ovf=%b exp all 0", rdata1, rdata2, busy1, busy2, sb_ovf);
    end
    idle();
    tick();
    rst = 1'b0;
    read_both(5'd5);
    raddr2 = 5'd8;
    #1;
    n_tests++;
    if (rdata1 !== 32'h0 || busy2 !== 1'b0) begin
      n_fail++; $display("FAIL post_rst rd1=%h busy2=%b exp 0/0", rdata1, busy2);
    end
  endtask

  task automatic test_write();
    do_reset();
    wback(5'd5, 32'hDEAD_BEEF);
    read_both(5'd5);
    exp_q.push_back(32'hDEAD_BEEF);
    e = exp_q.pop_front(); n_tests++;
    if (rdata1 !== e || rdata2 !== e) begin
      n_fail++; $display("FAIL write_r5 rd1=%h rd2=%h exp=%h", rdata1, rdata2, e);
    end
    // Register 0 ignores writes and issues, bypass included.
    idle(); wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'h1234;
    iss_we = 1'b1; iss_waddr = 5'd0; re1 = 1'b1; raddr1 = 5'd0;
    #1;
    n_tests++;
    if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL r0_bypass got=%h exp=0", rdata1); end
    tick();
    read_both(5'd0);
    n_tests++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL r0_read rd1=%h rd2=%h busy1=%b exp 0", rdata1, rdata2, busy1);
    end
    // re=0 suppresses data and busy.
    idle(); raddr1 = 5'd5;
    #1;
    n_tests++;
    if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL re_off got=%h exp=0", rdata1); end
    tick();
  endtask

  task automatic test_bypass();
    idle(); wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'hA5A5_A5A5;
    re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
    exp_q.push_back(32'hA5A5_A5A5);
    #1;
    e = exp_q.pop_front(); n_tests++;
    if (rdata1 !== e || rdata2 !== e) begin
      n_fail++; $display("FAIL bypass_r7 rd1=%h rd2=%h exp=%h", rdata1, rdata2, e);
    end
    tick();
    read_both(5'd7);
    n_tests++;
    if (rdata1 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL bypass_stored got=%h exp=a5a5a5a5", rdata1); end
    tick();
  endtask

  task automatic test_busy_drain();
    do_reset();
    issue(5'd3);
    issue(5'd3);
    read_both(5'd3);
    n_tests++;
    if (busy1 !== 1'b1) begin n_fail++; $display("FAIL drain_cnt2 busy1=%b exp=1", busy1); end
    idle(); wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h0000_1111; re1 = 1'b1; raddr1 = 5'd3;
    #1;
    n_tests++;
    if (busy1 !== 1'b1 || rdata1 !== 32'h0000_1111) begin
      n_fail++; $display("FAIL drain_wb1 busy1=%b rd1=%h exp 1/00001111", busy1, rdata1);
    end
    tick();
    wb_wdata = 32'h0000_2222;
    #1;
    n_tests++;
    if (busy1 !== 1'b0 || rdata1 !== 32'h0000_2222) begin
      n_fail++; $display("FAIL drain_wb2 busy1=%b rd1=%h exp 0/00002222", busy1, rdata1);
    end
    tick();
    read_both(5'd3);
    n_tests++;
    if (busy1 !== 1'b0 || rdata1 !== 32'h0000_2222 || sb_ovf !== 1'b0) begin
      n_fail++; $display("FAIL drain_done busy1=%b rd1=%h ovf=%b exp 0/00002222/0", busy1, rdata1, sb_ovf);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(5'd9);
    issue(5'd4);
    idle(); iss_we = 1'b1; iss_waddr = 5'd9; wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'h99;
    tick();
    read_both(5'd9);
    n_tests++;
    if (busy1 !== 1'b1) begin n_fail++; $display("FAIL same_reg_hold busy1=%b exp=1", busy1); end
    idle(); iss_we = 1'b1; iss_waddr = 5'd9; wb_we = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'h44;
    tick();
    idle(); re1 = 1'b1; raddr1 = 5'd4; re2 = 1'b1; raddr2 = 5'd9;
    #1;
    n_tests++;
    if (busy1 !== 1'b0 || busy2 !== 1'b1) begin
      n_fail++; $display("FAIL diff_reg busy1=%b busy2=%b exp 0/1", busy1, busy2);
    end
    // r9 should now hold 2 pending writes.
    wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'h9A;
    #1;
    n_tests++;
    if (busy2 !== 1'b1) begin n_fail++; $display("FAIL r9_cnt2 busy2=%b exp=1", busy2); end
    tick();
    n_tests++;
    if (busy2 !== 1'b0 || rdata2 !== 32'h9A) begin
      n_fail++; $display("FAIL r9_last busy2=%b rd2=%h exp 0/9a", busy2, rdata2);
    end
    tick();
    read_both(5'd9);
    n_tests++;
    if (busy1 !== 1'b0 || sb_ovf !== 1'b0) begin
      n_fail++; $display("FAIL r9_empty busy1=%b ovf=%b exp 0/0", busy1, sb_ovf);
    end
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 3; i++) issue(5'd2);
    idle(); #1;
    n_tests++;
    if (sb_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_at3 got=%b exp=0", sb_ovf); end
    issue(5'd2);
    read_both(5'd2);
    n_tests++;
    if (sb_ovf !== 1'b1 || busy1 !== 1'b1) begin
      n_fail++; $display("FAIL ovf_at4 ovf=%b busy1=%b exp 1/1", sb_ovf, busy1);
    end
    wback(5'd2, 32'h1);
    wback(5'd2, 32'h2);
    read_both(5'd2);
    n_tests++;
    if (busy1 !== 1'b1) begin n_fail++; $display("FAIL ovf_hold3 busy1=%b exp=1", busy1); end
    wback(5'd2, 32'h3);
    read_both(5'd2);
    n_tests++;
    if (busy1 !== 1'b0 || sb_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drained busy1=%b ovf=%b exp 0/1", busy1, sb_ovf);
    end
    // Underflow: unmatched write-back.
    do_reset();
    wback(5'd6, 32'h66);
    read_both(5'd6);
    n_tests++;
    if (sb_ovf !== 1'b1 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL unf_set ovf=%b busy1=%b exp 1/0", sb_ovf, busy1);
    end
    issue(5'd6);
    wback(5'd6, 32'h67);
    tick();
    read_both(5'd6);
    n_tests++;
    if (busy1 !== 1'b0 || sb_ovf !== 1'b1 || rdata1 !== 32'h67) begin
      n_fail++; $display("FAIL unf_hold0 busy1=%b ovf=%b rd1=%h exp 0/1/67", busy1, sb_ovf, rdata1);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    do_reset();
    for (int a = 0; a < 32; a++) model_mem[a] = '0;
    for (int i = 0; i < 60; i++) begin
      idle();
      wb_we  = 1'($urandom_range(0, 1));
      wb_waddr = 5'($urandom_range(0, 31));
      wb_wdata = $urandom;
      re1 = 1'($urandom_range(0, 3) != 0); raddr1 = 5'($urandom_range(0, 31));
      re2 = 1'($urandom_range(0, 3) != 0); raddr2 = ($urandom_range(0, 3) == 0) ? wb_waddr : 5'($urandom_range(0, 31));
      if (!re1 || raddr1 == 0) e1 = '0;
      else if (wb_we && wb_waddr == raddr1) e1 = wb_wdata;
      else e1 = model_mem[raddr1];
      if (!re2 || raddr2 == 0) e2 = '0;
      else if (wb_we && wb_waddr == raddr2) e2 = wb_wdata;
      else e2 = model_mem[raddr2];
      exp_q.push_back(e1);
      exp_q.push_back(e2);
      #1;
      e = exp_q.pop_front(); n_tests++;
      if (rdata1 !== e) begin n_fail++; $display("FAIL rand_rd1 i=%0d a=%0d got=%h exp=%h", i, raddr1, rdata1, e); end
      e = exp_q.pop_front(); n_tests++;
      if (rdata2 !== e) begin n_fail++; $display("FAIL rand_rd2 i=%0d a=%0d got=%h exp=%h", i, raddr2, rdata2, e); end
      n_tests++;
      if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
        n_fail++; $display("FAIL rand_busy i=%0d b1=%b b2=%b exp 0/0", i, busy1, busy2);
      end
      if (wb_we && wb_waddr != 0) model_mem[wb_waddr] = wb_wdata;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_write();
    test_bypass();
    test_busy_drain();
    test_back_to_back();
    test_overflow();
    test_random();
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL exp_q_left size=%0d exp=0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- General-purpose register file: the consumer of the write-back stream produced by the MEM/WB pipeline register (wb_wdata, wb_waddr, wb_we).
- Serves the decode stage with two read ports. Forwards same-cycle write-back data.
- Holds a per-register pending-write scoreboard so decode can detect RAW hazards on writes still in flight.

Parameters:
- DATA_W, 32, data width; matches the data bus.
- ADDR_W, 5, register address width; matches the register address bus.
- CNT_W, 2, width of each per-register in-flight counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- wb_we  in  1  write-back enable.
- wb_waddr  in  ADDR_W  write-back destination register.
- wb_wdata  in  DATA_W  write-back data.
- iss_we  in  1  decode issues an instruction that will write a register.
- iss_waddr  in  ADDR_W  destination register of the issued instruction.
- re1  in  1  read port 1 enable.
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data.
- busy1  out  1  raddr1 has an outstanding write.
- re2, raddr2, rdata2, busy2: same as port 1.
- sb_ovf  out  1  sticky scoreboard overflow flag.

Behaviour:
- Reset (asynchronous):
  - All 2^ADDR_W registers cleared to 0.
  - All counters cleared to 0.
  - sb_ovf cleared to 0.
  - While rst=1: rdata1/rdata2 = 0 and busy1/busy2 = 0.
  - Reset asserted mid-operation discards all in-flight state immediately.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and issues to address 0 are ignored; its counter never changes.
- Write:
  - On the rising clk edge with wb_we=1 and wb_waddr!=0: reg[wb_waddr] <= wb_wdata.
- Read (combinational, zero latency):
  - re=0 -> rdata=0, busy=0.
  - re=1, raddr=0 -> rdata=0.
  - re=1, wb_we=1, raddr==wb_waddr!=0 -> rdata=wb_wdata (write-through bypass).
  - Otherwise rdata=reg[raddr].
  - Both ports are independent and may read the same address.
- Scoreboard: one CNT_W-bit counter per register, updated on each clock edge.
  - inc = iss_we and iss_waddr==r and r!=0.
  - dec = wb_we and wb_waddr==r and r!=0.
  - inc only -> cnt+1. If cnt is already max (3): hold at max and set sb_ovf.
  - dec only -> cnt-1. If cnt is already 0: hold at 0 and set sb_ovf (unmatched write-back).
  - inc and dec on the same register in the same cycle -> cnt unchanged.
  - inc and dec on different registers in the same cycle -> both applied.
- Busy output (combinational):
  - busy = re and raddr!=0 and cnt[raddr]!=0 and not (wb_we and wb_waddr==raddr and cnt[raddr]==1).
  - The final write-back lands this cycle and its data is bypassed, so the register is not reported busy.
- sb_ovf: sticky until reset.

Test Plan:
- Reset then read all addresses with re=1 -> rdata=0, busy=0, sb_ovf=0. Assert rst mid-sequence after writes -> all zero immediately, without waiting for a clk edge.
- Write-back r5=0xDEADBEEF, then read r5 the next cycle -> 0xDEADBEEF. Write-back r0=0x1234 -> r0 reads 0.
- wb_we=1, wb_waddr=7, wb_wdata=0xA5A5A5A5 while raddr1=raddr2=7 in the same cycle -> both ports return 0xA5A5A5A5 before the edge.
- Issue r3 for two cycles (cnt=2) -> busy1=1. First write-back -> busy1 stays 1. Second write-back cycle -> busy1=0 combinationally and data is bypassed; cnt=0 after the edge.
- Issue r9 and write-back r9 in the same cycle with cnt=1 -> cnt stays 1, busy stays 1 on the next cycle. Issue r9 and write-back r4 in the same cycle -> cnt[9]+1 and cnt[4]-1.
- Four issues to r2 without write-back -> cnt holds 3 and sb_ovf=1. Reset, then write-back r6 with cnt=0 -> sb_ovf=1 and cnt stays 0.
